// File: rtl/arbiter_rr_lock.sv
// rtl/arbiter_rr_lock.sv - fixed-priority / round-robin arbiter with registered one-hot grant and burst lock
module arbiter_rr_lock #(
  parameter int VECTOR_IN = 8,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [VECTOR_IN-1:0]         request_vector,
  input  logic [VECTOR_IN-1:0]         lock_vector,
  input  logic                         grant_ready,
  output logic [VECTOR_IN-1:0]         grant,
  output logic                         grant_valid,
  output logic [$clog2(VECTOR_IN)-1:0] grant_id
);

  localparam int IDW = $clog2(VECTOR_IN);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_next;
  logic [IDW-1:0]       owner, owner_next;
  logic [IDW-1:0]       ptr, ptr_next;
  logic [HW-1:0]        hold_cnt, hold_next;
  logic [VECTOR_IN-1:0] owner_oh;
  logic [VECTOR_IN-1:0] masked;

  // First set request scanning upward from p (wrapping) in round-robin, from 0 in fixed mode.
  function automatic logic [IDW-1:0] pick(input logic [VECTOR_IN-1:0] req,
                                          input logic                 rr,
                                          input logic [IDW-1:0]       p);
    logic [IDW-1:0] w;
    logic           found;
    int             j;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < VECTOR_IN; i++) begin
      j = i + (rr ? int'(p) : 0);
      if (j >= VECTOR_IN) j = j - VECTOR_IN;
      if (!found && req[j]) begin
        found = 1'b1;
        w     = IDW'(j);
      end
    end
    return w;
  endfunction

  assign owner_oh = VECTOR_IN'(1) << owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    hold_next  = hold_cnt;
    masked     = request_vector & ~owner_oh;
    case (state)
      IDLE: begin
        if (|request_vector) begin
          state_next = GRANT;
          owner_next = pick(request_vector, mode, ptr);
        end
      end
      GRANT: begin
        if (!request_vector[owner]) begin
          state_next = IDLE;
          hold_next  = '0;
        end else if (grant_ready) begin
          if (lock_vector[owner] && hold_cnt < HW'(MAX_HOLD - 1)) begin
            hold_next = hold_cnt + 1'b1;
          end else begin
            // Release: hand over in the same cycle so back-to-back owners see no bubble.
            hold_next = '0;
            if (mode) ptr_next = (owner == IDW'(VECTOR_IN - 1)) ? '0 : owner + 1'b1;
            if (|masked) begin
              state_next = GRANT;
              owner_next = pick(masked, mode, ptr_next);
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (state == GRANT) begin
      grant       = owner_oh;
      grant_valid = 1'b1;
      grant_id    = owner;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// tb/tb_arbiter_rr_lock.sv - table, directed and randomized model-based checks for arbiter_rr_lock
module tb_arbiter_rr_lock;

  localparam int N  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst, mode, grant_ready, grant_valid;
  logic [N-1:0] request_vector, lock_vector, grant;
  logic [2:0]   grant_id;

  int errors = 0;
  int checks = 0;

  arbiter_rr_lock #(.VECTOR_IN(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .request_vector(request_vector), .lock_vector(lock_vector),
    .grant_ready(grant_ready), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       m;
    logic [7:0] rq;
    logic [7:0] lk;
    logic       rdy;
    logic [7:0] eg;
    logic [2:0] eid;
  } vec_t;

  task automatic check(input string nm, input logic [7:0] eg, input logic [2:0] eid);
    logic ev;
    ev = |eg;
    checks++;
    if (grant !== eg || grant_id !== eid || grant_valid !== ev) begin
      errors++;
      $display("FAIL %s: grant=%h id=%0d valid=%b, expected grant=%h id=%0d valid=%b",
               nm, grant, grant_id, grant_valid, eg, eid, ev);
    end
  endtask

  task automatic apply(input logic r, input logic m, input logic [7:0] rq,
                       input logic [7:0] lk, input logic rdy);
    rst = r; mode = m; request_vector = rq; lock_vector = lk; grant_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic r, input logic m, input logic [7:0] rq,
                     input logic [7:0] lk, input logic rdy, input logic [7:0] eg,
                     input logic [2:0] eid);
    apply(r, m, rq, lk, rdy);
    check(nm, eg, eid);
  endtask

  // Reference model: current owner (-1 = none), rotation start, transfers kept under lock.
  int m_k, m_ptr, m_hold;

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic m, input logic [7:0] rq,
                            input logic [7:0] lk, input logic rdy);
    logic [7:0] others;
    if (r) begin
      m_k = -1; m_ptr = 0; m_hold = 0;
    end else if (m_k < 0) begin
      if (rq != 0) m_k = first_from(rq, m ? m_ptr : 0);
    end else if (!rq[m_k]) begin
      m_k = -1; m_hold = 0;
    end else if (rdy) begin
      if (lk[m_k] && m_hold + 1 < MH) begin
        m_hold++;
      end else begin
        m_hold = 0;
        if (m) m_ptr = (m_k + 1) % N;
        others = rq;
        others[m_k] = 1'b0;
        m_k = (others != 0) ? first_from(others, m ? m_ptr : 0) : -1;
      end
    end
  endtask

  vec_t tbl[$];
  logic [7:0] exp_g;
  logic [2:0] exp_id;
  logic       rr, rm, rrdy;
  logic [7:0] rreq, rlk;

  initial begin
    rst = 1'b1; mode = 1'b0; request_vector = '0; lock_vector = '0; grant_ready = 1'b0;

    // Reset state, fixed priority, then round-robin sweep over all requesters.
    tbl.push_back('{1'b1, 1'b0, 8'hA4, 8'h00, 1'b1, 8'h00, 3'd0});
    tbl.push_back('{1'b0, 1'b0, 8'hA4, 8'h00, 1'b0, 8'h04, 3'd2});
    tbl.push_back('{1'b0, 1'b0, 8'hA4, 8'h00, 1'b0, 8'h04, 3'd2});
    tbl.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 3'd0});
    for (int i = 0; i <= N; i++)
      tbl.push_back('{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h01 << (i % N), 3'(i % N)});
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("table[%0d]", i), tbl[i].r, tbl[i].m, tbl[i].rq, tbl[i].lk, tbl[i].rdy,
          tbl[i].eg, tbl[i].eid);

    // Lock: requester 3 keeps the grant for MAX_HOLD transfers, then 5; pointer ends at 4.
    cyc("lock_rst", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < MH; i++)
      cyc($sformatf("lock_hold%0d", i), 1'b0, 1'b1, 8'h28, 8'h08, 1'b1, 8'h08, 3'd3);
    cyc("lock_release", 1'b0, 1'b1, 8'h28, 8'h08, 1'b1, 8'h20, 3'd5);
    cyc("lock_abort5", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    cyc("lock_ptr4", 1'b0, 1'b1, 8'h14, 8'h00, 1'b0, 8'h10, 3'd4);

    // Backpressure: grant and pointer frozen while ready is low.
    cyc("bp_rst", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    cyc("bp_grant", 1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 8'h04, 3'd2);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 8'h04, 3'd2);
    cyc("bp_release", 1'b0, 1'b1, 8'h04, 8'h00, 1'b1, 8'h00, 3'd0);
    cyc("bp_ptr3", 1'b0, 1'b1, 8'h0C, 8'h00, 1'b0, 8'h08, 3'd3);

    // Abort: dropping the request frees the grant without moving the pointer.
    cyc("ab_rst", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    cyc("ab_grant", 1'b0, 1'b1, 8'h40, 8'h00, 1'b0, 8'h40, 3'd6);
    cyc("ab_drop", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    cyc("ab_ptr0", 1'b0, 1'b1, 8'h81, 8'h00, 1'b0, 8'h01, 3'd0);

    // Reset in the middle of a locked hold clears the grant and the pointer.
    cyc("rs_rst", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    cyc("rs_g1", 1'b0, 1'b1, 8'h02, 8'h00, 1'b1, 8'h02, 3'd1);
    cyc("rs_idle", 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0);
    cyc("rs_g3", 1'b0, 1'b1, 8'h28, 8'h08, 1'b1, 8'h08, 3'd3);
    cyc("rs_hold", 1'b0, 1'b1, 8'h28, 8'h08, 1'b1, 8'h08, 3'd3);
    cyc("rs_mid", 1'b1, 1'b1, 8'h28, 8'h08, 1'b1, 8'h00, 3'd0);
    cyc("rs_ptr0", 1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 8'h02, 3'd1);
    cyc("rs_again", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    cyc("rs_g7", 1'b0, 1'b1, 8'h80, 8'h00, 1'b0, 8'h80, 3'd7);

    // Randomized traffic against the reference model.
    rm = 1'b1; rreq = '0; rlk = '0;
    m_k = -1; m_ptr = 0; m_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rr = (c == 0) || ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) rm = ~rm;
      if ($urandom_range(0, 3) == 0) rreq = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rlk = 8'($urandom);
      rrdy = ($urandom_range(0, 3) != 0);
      apply(rr, rm, rreq, rlk, rrdy);
      model_step(rr, rm, rreq, rlk, rrdy);
      exp_g  = (m_k < 0) ? 8'h00 : (8'h01 << m_k);
      exp_id = (m_k < 0) ? 3'd0 : 3'(m_k);
      check($sformatf("rand[%0d]", c), exp_g, exp_id);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
